// File: rtl/ta_cap_wr.sv
// Capture writer: tags merged ADC words with sequence/overrange bits and streams them to capture memory.
// Optional decimation is enabled by defining CAP_DECIM_EN.
module ta_cap_wr #(
    parameter int ADC0_1 = 56,
    parameter int MEMA_0 = 12,
    parameter int MEMD_0 = ADC0_1 + 8
) (
    input  logic              clk62,
    input  logic              rst,
    input  logic              mem_reset,
    input  logic              cap_start,
    input  logic [MEMA_0-1:0] cap_len,
    input  logic [3:0]        cap_decim,
    input  logic [ADC0_1-1:0] merge_data,
    input  logic              mereg_datv,
    input  logic              adc_of,
    output logic              mem_we,
    output logic [MEMA_0-1:0] mem_addr,
    output logic [MEMD_0-1:0] mem_wdata,
    output logic              cap_busy,
    output logic              cap_done,
    output logic              cap_ovf,
    output logic [MEMA_0:0]   cap_wcnt
);

    localparam int CW = MEMA_0 + 1;

    typedef enum logic [1:0] {IDLE, CAPT, DONE} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   r_len;
    logic [3:0]      r_seq;
    logic            r_ofPend;
    logic [CW-1:0]   w_lenEff;
    logic [CW-1:0]   w_cntNext;
    logic            w_ofAcc;
    logic            w_decimOk;
    logic            w_accept;

    // A programmed length of zero means a full-depth capture.
    assign w_lenEff  = (cap_len == '0) ? (CW'(1) << MEMA_0) : {1'b0, cap_len};
    assign w_cntNext = r_cnt + CW'(1);
    assign w_ofAcc   = r_ofPend | adc_of;
    assign w_accept  = (r_state == CAPT) && mereg_datv && w_decimOk;

`ifdef CAP_DECIM_EN
    logic [3:0] r_decCnt;
    logic [3:0] r_decim;

    assign w_decimOk = (r_decCnt == 4'd0);

    always_ff @(posedge clk62) begin
        if (rst || mem_reset) begin
            r_decCnt <= 4'd0;
            r_decim  <= 4'd0;
        end else if (r_state != CAPT) begin
            if (cap_start) begin
                r_decCnt <= 4'd0;
                r_decim  <= cap_decim;
            end
        end else if (mereg_datv) begin
            r_decCnt <= (r_decCnt == r_decim) ? 4'd0 : r_decCnt + 4'd1;
        end
    end
`else
    logic w_unusedDecim;

    assign w_unusedDecim = ^cap_decim;
    assign w_decimOk     = 1'b1;
`endif

    // rst and mem_reset both return the block to an idle, all-zero state.
    always_ff @(posedge clk62) begin
        if (rst || mem_reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_len     <= '0;
            r_seq     <= 4'd0;
            r_ofPend  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cap_busy  <= 1'b0;
            cap_done  <= 1'b0;
            cap_ovf   <= 1'b0;
            cap_wcnt  <= '0;
        end else begin
            mem_we <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (cap_start) begin
                        r_state  <= CAPT;
                        r_cnt    <= '0;
                        r_len    <= w_lenEff;
                        r_seq    <= 4'd0;
                        r_ofPend <= 1'b0;
                        mem_addr <= '0;
                        cap_wcnt <= '0;
                        cap_ovf  <= 1'b0;
                        cap_busy <= 1'b1;
                        cap_done <= 1'b0;
                    end
                end
                CAPT: begin
                    if (adc_of) begin
                        cap_ovf <= 1'b1;
                    end
                    // Overrange seen on skipped cycles is carried into the next accepted word.
                    if (w_accept) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= r_cnt[MEMA_0-1:0];
                        mem_wdata <= {w_ofAcc, 3'b000, r_seq, merge_data};
                        r_cnt     <= w_cntNext;
                        cap_wcnt  <= w_cntNext;
                        r_seq     <= r_seq + 4'd1;
                        r_ofPend  <= 1'b0;
                        if (w_cntNext == r_len) begin
                            r_state  <= DONE;
                            cap_busy <= 1'b0;
                            cap_done <= 1'b1;
                        end
                    end else begin
                        r_ofPend <= w_ofAcc;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ta_cap_wr.sv
// Directed self-checking bench for ta_cap_wr (memory address width 4).
// Covers decimation when compiled with CAP_DECIM_EN.
module tb_ta_cap_wr;

    logic        clk62;
    logic        rst;
    logic        mem_reset;
    logic        cap_start;
    logic [3:0]  cap_len;
    logic [3:0]  cap_decim;
    logic [55:0] merge_data;
    logic        mereg_datv;
    logic        adc_of;
    logic        mem_we;
    logic [3:0]  mem_addr;
    logic [63:0] mem_wdata;
    logic        cap_busy;
    logic        cap_done;
    logic        cap_ovf;
    logic [4:0]  cap_wcnt;

    int nCompared;
    int nMismatched;
    int weCount;
    int baseCount;

    typedef struct {
        logic        rst;
        logic        start;
        logic        datv;
        logic [55:0] data;
        logic        of;
        logic [76:0] exp;
    } vec_t;

    vec_t tbl[16];

    ta_cap_wr #(.ADC0_1(56), .MEMA_0(4), .MEMD_0(64)) dut (
        .clk62(clk62), .rst(rst), .mem_reset(mem_reset), .cap_start(cap_start),
        .cap_len(cap_len), .cap_decim(cap_decim), .merge_data(merge_data),
        .mereg_datv(mereg_datv), .adc_of(adc_of), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cap_busy(cap_busy),
        .cap_done(cap_done), .cap_ovf(cap_ovf), .cap_wcnt(cap_wcnt)
    );

    initial clk62 = 1'b0;
    always #5 clk62 = ~clk62;

    // Write pulses are counted on the falling edge, away from output updates.
    always @(negedge clk62) if (mem_we) weCount = weCount + 1;

    function automatic logic [55:0] dataOf(input int k);
        logic [55:0] b;
        b = 56'h11111111111111;
        return b * 56'(k + 1);
    endfunction

    function automatic logic [63:0] mkWord(input logic of, input int idx, input logic [55:0] d);
        logic [3:0] s;
        s = 4'(idx);
        return {of, 3'b000, s, d};
    endfunction

    function automatic logic [76:0] pack(input logic we, input int addr, input logic [63:0] wd,
                                         input logic busy, input logic done, input logic ovf,
                                         input int wcnt);
        return {we, 4'(addr), wd, busy, done, ovf, 5'(wcnt)};
    endfunction

    task automatic applyStimulus(input logic start, input logic datv, input logic [55:0] data,
                                 input logic of);
        cap_start  = start;
        mereg_datv = datv;
        merge_data = data;
        adc_of     = of;
        @(posedge clk62);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        nCompared = nCompared + 1;
        if (act !== exp) begin
            nMismatched = nMismatched + 1;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 56'h0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        nCompared   = 0;
        nMismatched = 0;
        weCount     = 0;
        rst         = 1'b1;
        mem_reset   = 1'b0;
        cap_start   = 1'b0;
        cap_len     = 4'd4;
        cap_decim   = 4'd0;
        merge_data  = 56'h0;
        mereg_datv  = 1'b0;
        adc_of      = 1'b0;

        // Test 1 table: reset, start, four words spaced four cycles apart.
        n = 0;
        tbl[n] = '{1'b1, 1'b0, 1'b0, 56'h0, 1'b0, pack(0, 0, 64'h0, 0, 0, 0, 0)};
        n = n + 1;
        tbl[n] = '{1'b0, 1'b1, 1'b0, 56'h0, 1'b0, pack(0, 0, 64'h0, 1, 0, 0, 0)};
        n = n + 1;
        for (int k = 0; k < 4; k++) begin
            tbl[n] = '{1'b0, 1'b0, 1'b1, dataOf(k), 1'b0,
                       pack(1, k, mkWord(0, k, dataOf(k)), k != 3, k == 3, 0, k + 1)};
            n = n + 1;
            for (int g = 0; g < ((k == 3) ? 1 : 3); g++) begin
                tbl[n] = '{1'b0, 1'b0, 1'b0, 56'h0, 1'b0,
                           pack(0, k, mkWord(0, k, dataOf(k)), k != 3, k == 3, 0, k + 1)};
                n = n + 1;
            end
        end
        for (int i = 0; i < 16; i++) begin
            rst = tbl[i].rst;
            applyStimulus(tbl[i].start, tbl[i].datv, tbl[i].data, tbl[i].of);
            checkOutput($sformatf("t1 row%0d", i),
                        {mem_we, mem_addr, mem_wdata, cap_busy, cap_done, cap_ovf, cap_wcnt},
                        tbl[i].exp);
        end
        rst = 1'b0;

        // Test 2: overrange between words 2 and 3 tags only word 3.
        doReset();
        cap_len = 4'd8;
        applyStimulus(1'b1, 1'b0, 56'h0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            if (k == 3) begin
                applyStimulus(1'b0, 1'b0, 56'h0, 1'b1);
                checkOutput("t2 ovfSet", cap_ovf, 1'b1);
            end
            applyStimulus(1'b0, 1'b1, dataOf(k), 1'b0);
            checkOutput($sformatf("t2 word%0d", k), {mem_we, mem_addr, mem_wdata},
                        {1'b1, 4'(k), mkWord(k == 3, k, dataOf(k))});
        end
        checkOutput("t2 doneState", {cap_busy, cap_done, cap_ovf, cap_wcnt}, {3'b011, 5'd8});
        applyStimulus(1'b0, 1'b0, 56'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 56'h0, 1'b0);
        checkOutput("t2 ovfHeld", {mem_we, cap_done, cap_ovf}, 3'b011);
        applyStimulus(1'b1, 1'b0, 56'h0, 1'b0);
        checkOutput("t2 restart", {cap_busy, cap_done, cap_ovf, cap_wcnt}, {3'b100, 5'd0});

        // Test 3: zero length means full depth, no address wrap.
        doReset();
        cap_len = 4'd0;
        applyStimulus(1'b1, 1'b0, 56'h0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b0, 1'b1, dataOf(k), 1'b0);
            checkOutput($sformatf("t3 word%0d", k),
                        {mem_we, mem_addr, mem_wdata[59:56], cap_busy, cap_done, cap_wcnt},
                        {1'b1, 4'(k), 4'(k), k != 15, k == 15, 5'(k + 1)});
        end
        applyStimulus(1'b0, 1'b1, dataOf(16), 1'b0);
        checkOutput("t3 noWrap", {mem_we, cap_done, cap_wcnt}, {2'b01, 5'd16});

        // Test 4: mem_reset aborts after three writes.
        doReset();
        cap_len   = 4'd8;
        baseCount = weCount;
        applyStimulus(1'b1, 1'b0, 56'h0, 1'b0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, dataOf(k), 1'b0);
        checkOutput("t4 thirdWrite", {mem_we, mem_addr}, {1'b1, 4'd2});
        mem_reset = 1'b1;
        applyStimulus(1'b0, 1'b1, dataOf(3), 1'b1);
        checkOutput("t4 cleared", {mem_we, mem_addr, mem_wdata, cap_busy, cap_done, cap_ovf, cap_wcnt},
                    77'h0);
        applyStimulus(1'b1, 1'b1, dataOf(4), 1'b0);
        checkOutput("t4 heldIdle", {mem_we, cap_busy, cap_done}, 3'b000);
        mem_reset = 1'b0;
        applyStimulus(1'b0, 1'b1, dataOf(5), 1'b0);
        applyStimulus(1'b0, 1'b0, 56'h0, 1'b0);
        checkOutput("t4 writeCount", weCount - baseCount, 3);
        applyStimulus(1'b1, 1'b0, 56'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, dataOf(7), 1'b0);
        checkOutput("t4 restartAddr0", {mem_we, mem_addr, cap_wcnt}, {1'b1, 4'd0, 5'd1});

        // Test 5: coincident datv skipped, second start ignored.
        doReset();
        cap_len   = 4'd5;
        baseCount = weCount;
        applyStimulus(1'b1, 1'b1, 56'hDEADBEEF, 1'b0);
        checkOutput("t5 coincident", {mem_we, cap_busy, cap_wcnt}, {2'b01, 5'd0});
        for (int k = 0; k < 6; k++) begin
            applyStimulus(k == 2, 1'b1, dataOf(k), 1'b0);
            if (k < 5)
                checkOutput($sformatf("t5 word%0d", k), {mem_we, mem_addr, mem_wdata[55:0], cap_wcnt},
                            {1'b1, 4'(k), dataOf(k), 5'(k + 1)});
            else
                checkOutput("t5 afterDone", {mem_we, cap_done, cap_wcnt}, {2'b01, 5'd5});
        end
        applyStimulus(1'b0, 1'b0, 56'h0, 1'b0);
        checkOutput("t5 writeCount", weCount - baseCount, 5);

        // Test 6: decimation (or its absence in the default build).
        doReset();
        cap_len   = 4'd3;
        cap_decim = 4'd2;
        baseCount = weCount;
        applyStimulus(1'b1, 1'b0, 56'h0, 1'b0);
`ifdef CAP_DECIM_EN
        for (int j = 0; j < 9; j++) begin
            applyStimulus(1'b0, 1'b1, dataOf(j), j == 1);
            if (j % 3 == 0)
                checkOutput($sformatf("t6 keep%0d", j), {mem_we, mem_addr, mem_wdata, cap_done},
                            {1'b1, 4'(j / 3), mkWord(j == 3, j / 3, dataOf(j)), j == 6});
            else
                checkOutput($sformatf("t6 skip%0d", j), {mem_we, cap_done}, {1'b0, j > 6});
        end
        applyStimulus(1'b0, 1'b0, 56'h0, 1'b0);
        checkOutput("t6 writeCount", weCount - baseCount, 3);
`else
        for (int j = 0; j < 4; j++) begin
            applyStimulus(1'b0, 1'b1, dataOf(j), 1'b0);
            if (j < 3)
                checkOutput($sformatf("t6 word%0d", j), {mem_we, mem_addr, mem_wdata, cap_done},
                            {1'b1, 4'(j), mkWord(0, j, dataOf(j)), j == 2});
            else
                checkOutput("t6 afterDone", {mem_we, cap_done, cap_wcnt}, {2'b01, 5'd3});
        end
        applyStimulus(1'b0, 1'b0, 56'h0, 1'b0);
        checkOutput("t6 writeCount", weCount - baseCount, 3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
